// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the buffered instruction-fetch stage.
// Queue entries are packed as {pc[XLEN-1:0], instr[XLEN-1:0]}.
package fetch_pkg;

   localparam int          XLEN_DEFAULT      = 32;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   localparam int          PC_INCR           = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries toward decode.
// Flush clears the occupancy in one cycle; stored data is left as is.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW = clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // NOTE: sequential state is updated with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // NOTE: the storage array has no reset; entries are only visible once count covers them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];
   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == '0);

endmodule

// File: rtl/fetch_unit_buffered.sv
// Decoupled instruction fetch: credit-limited imem requests, in-order responses
// into a small queue toward decode, and redirect-driven squash of in-flight fetches.
module fetch_unit_buffered
   import fetch_pkg::*;
#(
   parameter int              XLEN            = XLEN_DEFAULT,
   parameter int              FIFO_DEPTH      = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = '0,
   parameter logic [XLEN-1:0] NOP_INSTR       = XLEN'(NOP_INSTR_DEFAULT)
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_instr,
   output logic [XLEN-1:0] dec_pc,
   output logic [XLEN-1:0] dec_pc_plus4
);

   localparam int CW = clog2(FIFO_DEPTH) + 1;
   localparam int OW = clog2(MAX_OUTSTANDING + 1);

   logic [XLEN-1:0]   fetch_pc;
   logic [XLEN-1:0]   rsp_pc;
   logic [OW-1:0]     outstanding;
   logic [OW-1:0]     kill;
   logic [CW-1:0]     count;
   logic              full;
   logic              empty;
   logic              issue;
   logic              push;
   logic              pop;
   logic [2*XLEN-1:0] head;
   logic [XLEN-1:0]   head_pc;

   // A request is only offered if its eventual response is guaranteed a queue slot.
   always_comb begin
      // NOTE: default first so no path through the block leaves the output unassigned (no latch).
      imem_req_valid = 1'b0;
      if (rst && !redirect && (int'(outstanding) < MAX_OUTSTANDING) &&
          (int'(outstanding) + int'(count) < FIFO_DEPTH))
         imem_req_valid = 1'b1;
   end

   assign imem_req_addr = fetch_pc;
   assign issue         = imem_req_valid && imem_req_ready;
   assign push          = rst && imem_rsp_valid && (kill == '0) && !redirect;
   assign dec_valid     = rst && !empty;
   assign pop           = dec_valid && dec_ready;

   assign head_pc      = head[2*XLEN-1:XLEN];
   assign dec_instr    = dec_valid ? head[XLEN-1:0] : NOP_INSTR;
   assign dec_pc       = dec_valid ? head_pc : '0;
   assign dec_pc_plus4 = dec_valid ? head_pc + XLEN'(PC_INCR) : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         kill        <= '0;
      end else if (redirect) begin
         fetch_pc    <= redirect_pc;
         rsp_pc      <= redirect_pc;
         outstanding <= outstanding - OW'(imem_rsp_valid);
         kill        <= outstanding - OW'(imem_rsp_valid);
      end else begin
         if (issue) fetch_pc <= fetch_pc + XLEN'(PC_INCR);
         outstanding <= outstanding + OW'(issue) - OW'(imem_rsp_valid);
         if (imem_rsp_valid) begin
            if (kill != '0) kill <= kill - OW'(1);
            else            rsp_pc <= rsp_pc + XLEN'(PC_INCR);
         end
      end
   end

   fetch_queue #(
      .WIDTH (2*XLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (push),
      .push_data ({rsp_pc, imem_rsp_data}),
      .pop       (pop),
      .head_data (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));
   a_rsp_expected: assert property (@(posedge clk) disable iff (!rst) imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_unit_buffered.sv
// Directed bench for fetch_unit_buffered: per-cycle vector table plus hand-built
// sequences for redirect, request back-pressure and a wrapping reset PC.
module tb_fetch_unit_buffered;

   logic        clk = 1'b0;
   logic        rst         [2];
   logic        redirect    [2];
   logic [31:0] redirect_pc [2];
   logic        req_valid   [2];
   logic        req_ready   [2];
   logic [31:0] req_addr    [2];
   logic        rsp_valid   [2];
   logic [31:0] rsp_data    [2];
   logic        dec_valid   [2];
   logic        dec_ready   [2];
   logic [31:0] dec_instr   [2];
   logic [31:0] dec_pc      [2];
   logic [31:0] dec_pc_plus4[2];

   int n_cmp  = 0;
   int n_fail = 0;

   // Memory model: in-order, fixed latency per channel, mem[a] = a | 0x13.
   logic [31:0] q_addr [2][16];
   int          q_due  [2][16];
   int          q_head [2];
   int          q_tail [2];
   int          lat    [2];
   int          cyc = 0;

   always #5 clk = ~clk;

   fetch_unit_buffered dut_a (
      .clk(clk), .rst(rst[0]), .redirect(redirect[0]), .redirect_pc(redirect_pc[0]),
      .imem_req_valid(req_valid[0]), .imem_req_ready(req_ready[0]), .imem_req_addr(req_addr[0]),
      .imem_rsp_valid(rsp_valid[0]), .imem_rsp_data(rsp_data[0]),
      .dec_valid(dec_valid[0]), .dec_ready(dec_ready[0]), .dec_instr(dec_instr[0]),
      .dec_pc(dec_pc[0]), .dec_pc_plus4(dec_pc_plus4[0])
   );

   fetch_unit_buffered #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
      .clk(clk), .rst(rst[1]), .redirect(redirect[1]), .redirect_pc(redirect_pc[1]),
      .imem_req_valid(req_valid[1]), .imem_req_ready(req_ready[1]), .imem_req_addr(req_addr[1]),
      .imem_rsp_valid(rsp_valid[1]), .imem_rsp_data(rsp_data[1]),
      .dec_valid(dec_valid[1]), .dec_ready(dec_ready[1]), .dec_instr(dec_instr[1]),
      .dec_pc(dec_pc[1]), .dec_pc_plus4(dec_pc_plus4[1])
   );

   always @(posedge clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         if (!rst[ch]) begin
            q_head[ch] <= 0;
            q_tail[ch] <= 0;
         end else begin
            if (rsp_valid[ch]) q_head[ch] <= q_head[ch] + 1;
            if (req_valid[ch] && req_ready[ch]) begin
               q_addr[ch][q_tail[ch] % 16] <= req_addr[ch];
               q_due[ch][q_tail[ch] % 16]  <= cyc + lat[ch];
               q_tail[ch] <= q_tail[ch] + 1;
            end
         end
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         if (q_head[ch] != q_tail[ch] && q_due[ch][q_head[ch] % 16] <= cyc) begin
            rsp_valid[ch] = 1'b1;
            rsp_data[ch]  = q_addr[ch][q_head[ch] % 16] | 32'h13;
         end else begin
            rsp_valid[ch] = 1'b0;
            rsp_data[ch]  = '0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   // Expected head fields are derived from the PC alone.
   task automatic check_head(input int ch, input string tag, input logic [31:0] pc);
      check({tag, " dec_valid"}, 32'(dec_valid[ch]), 32'd1);
      check({tag, " dec_pc"}, dec_pc[ch], pc);
      check({tag, " dec_instr"}, dec_instr[ch], pc | 32'h13);
      check({tag, " dec_pc_plus4"}, dec_pc_plus4[ch], pc + 32'd4);
   endtask

   task automatic check_req(input int ch, input string tag, input logic v, input logic [31:0] a);
      check({tag, " req_valid"}, 32'(req_valid[ch]), 32'(v));
      check({tag, " req_addr"}, req_addr[ch], a);
   endtask

   // One reset cycle with outputs checked; returns at the start of the first live cycle (T0).
   task automatic reset_ch(input int ch);
      @(negedge clk);
      rst[ch] = 1'b0; redirect[ch] = 1'b0; req_ready[ch] = 1'b1; dec_ready[ch] = 1'b1;
      #1;
      check("reset req_valid", 32'(req_valid[ch]), 32'd0);
      check("reset dec_valid", 32'(dec_valid[ch]), 32'd0);
      check("reset dec_instr", dec_instr[ch], 32'h13);
      check("reset dec_pc", dec_pc[ch], 32'd0);
      check("reset dec_pc_plus4", dec_pc_plus4[ch], 32'd0);
      @(negedge clk);
      rst[ch] = 1'b1;
   endtask

   typedef struct {
      logic        rst_before;
      logic        dec_ready;
      logic        exp_req_valid;
      logic [31:0] exp_req_addr;
      logic        exp_dec_valid;
      logic [31:0] exp_dec_pc;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   initial begin
      for (int ch = 0; ch < 2; ch++) begin
         rst[ch] = 1'b0; redirect[ch] = 1'b0; redirect_pc[ch] = '0;
         req_ready[ch] = 1'b1; dec_ready[ch] = 1'b1; lat[ch] = 1;
         q_head[ch] = 0; q_tail[ch] = 0;
      end

      // Rows 0-5: streaming from reset. Rows 6-23: decode stalled 10 cycles, then drained.
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
      for (int i = 10; i <= 15; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
      vecs[17] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
      vecs[18] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
      vecs[19] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
      vecs[20] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
      vecs[21] = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
      vecs[22] = '{1'b0, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
      vecs[23] = '{1'b0, 1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].rst_before) reset_ch(0);
         else @(negedge clk);
         dec_ready[0] = vecs[i].dec_ready;
         #1;
         check_req(0, $sformatf("vec%0d", i), vecs[i].exp_req_valid, vecs[i].exp_req_addr);
         check($sformatf("vec%0d dec_valid", i), 32'(dec_valid[0]), 32'(vecs[i].exp_dec_valid));
         if (vecs[i].exp_dec_valid) check_head(0, $sformatf("vec%0d", i), vecs[i].exp_dec_pc);
         else check($sformatf("vec%0d nop", i), dec_instr[0], 32'h13);
      end

      // Latency 3: redirect with 0x8 and 0xC in flight; both responses must be dropped.
      lat[0] = 3;
      reset_ch(0);
      repeat (4) @(negedge clk);
      #1 check_head(0, "lat3 T4", 32'h0);
      @(negedge clk);
      #1 check_head(0, "lat3 T5", 32'h4);
      @(negedge clk);
      redirect[0] = 1'b1; redirect_pc[0] = 32'h100;
      #1 check("lat3 redirect req_valid", 32'(req_valid[0]), 32'd0);
      @(negedge clk);
      redirect[0] = 1'b0;
      #1 check_req(0, "lat3 T7", 1'b0, 32'h100);
      for (int t = 7; t <= 11; t++) begin
         if (t > 7) @(negedge clk);
         #1 check($sformatf("lat3 T%0d dec_valid", t), 32'(dec_valid[0]), 32'd0);
      end
      @(negedge clk);
      #1 check_head(0, "lat3 T12", 32'h100);

      // Latency 2: redirect coincides with a response and a pop, one request still unanswered.
      lat[0] = 2;
      reset_ch(0);
      dec_ready[0] = 1'b0;
      repeat (5) @(negedge clk);
      dec_ready[0] = 1'b1; redirect[0] = 1'b1; redirect_pc[0] = 32'h300;
      #1 check_head(0, "same T5", 32'h0);
      @(negedge clk);
      redirect[0] = 1'b0;
      #1;
      check("same T6 dec_valid", 32'(dec_valid[0]), 32'd0);
      check("same T6 dec_instr", dec_instr[0], 32'h13);
      check("same T6 kill", 32'(dut_a.kill), 32'd1);
      check_req(0, "same T6", 1'b1, 32'h300);
      for (int t = 7; t <= 8; t++) begin
         @(negedge clk);
         #1 check($sformatf("same T%0d dec_valid", t), 32'(dec_valid[0]), 32'd0);
      end
      @(negedge clk);
      #1 check_head(0, "same T9", 32'h300);

      // imem back-pressure: address held, queue drains, fetch resumes at held address.
      lat[0] = 1;
      reset_ch(0);
      repeat (3) @(negedge clk);
      req_ready[0] = 1'b0;
      #1 check_head(0, "bp T3", 32'h4);
      for (int t = 3; t <= 7; t++) begin
         if (t > 3) @(negedge clk);
         #1 check_req(0, $sformatf("bp T%0d", t), 1'b1, 32'h0C);
         if (t == 4) check_head(0, "bp T4", 32'h8);
         if (t >= 5) check($sformatf("bp T%0d dec_valid", t), 32'(dec_valid[0]), 32'd0);
      end
      @(negedge clk);
      req_ready[0] = 1'b1;
      #1 check_req(0, "bp T8", 1'b1, 32'h0C);
      @(negedge clk);
      #1 check_req(0, "bp T9", 1'b1, 32'h10);
      @(negedge clk);
      #1 check_head(0, "bp T10", 32'h0C);

      // Wrapping reset PC, then reset asserted mid-stream.
      reset_ch(1);
      #1 check_req(1, "wrap T0", 1'b1, 32'hFFFF_FFF8);
      @(negedge clk);
      #1 check_req(1, "wrap T1", 1'b1, 32'hFFFF_FFFC);
      @(negedge clk);
      #1 check_req(1, "wrap T2", 1'b1, 32'h0000_0000);
      check_head(1, "wrap T2", 32'hFFFF_FFF8);
      @(negedge clk);
      #1 check_head(1, "wrap T3", 32'hFFFF_FFFC);
      check("wrap T3 plus4 wraps", dec_pc_plus4[1], 32'h0);
      @(negedge clk);
      #1 check_head(1, "wrap T4", 32'h0);
      @(negedge clk);
      rst[1] = 1'b0;
      #1 check("wrap rst dec_valid", 32'(dec_valid[1]), 32'd0);
      check("wrap rst req_valid", 32'(req_valid[1]), 32'd0);
      @(negedge clk);
      rst[1] = 1'b1;
      #1 check("wrap post-rst dec_valid", 32'(dec_valid[1]), 32'd0);
      check_req(1, "wrap post-rst", 1'b1, 32'hFFFF_FFF8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
